// File: rtl/lzw_ct_pkg.sv
// Shared types for the LZW conflict CAM: request opcodes and controller states.
package lzw_ct_pkg;

    typedef enum logic [1:0] {
        CT_LOOKUP = 2'd0,
        CT_INSERT = 2'd1,
        CT_CLEAR  = 2'd2
    } ct_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ct_state_e;

endpackage

// File: rtl/ct_prio_enc.sv
// Lowest-index-wins priority encoder over a DEPTH-bit hit vector.
module ct_prio_enc #(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] hits,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        any   = |hits;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            index = hits[i] ? IDX_W'(i) : index;
        end
    end

endmodule

// File: rtl/conflict_cam.sv
// Fully associative (data, hash, map) store resolving LZW dictionary hash collisions.
module conflict_cam
    import lzw_ct_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 64,
    parameter int HASH_WIDTH = 12,
    parameter int REPLACE    = 0,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [HASH_WIDTH-1:0] req_hash,
    input  logic [HASH_WIDTH-1:0] req_map,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic                  rsp_drop,
    output logic [IDX_W-1:0]      rsp_index,
    output logic [HASH_WIDTH-1:0] rsp_hash,
    output logic [HASH_WIDTH-1:0] rsp_map,
    output logic [IDX_W:0]        count,
    output logic                  full,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] data_r [DEPTH];
    logic [HASH_WIDTH-1:0] hash_r [DEPTH];
    logic [HASH_WIDTH-1:0] map_r  [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    ct_state_e             state_r;
    logic [IDX_W-1:0]      clr_idx_r;
    logic [IDX_W-1:0]      victim_r;
    logic [IDX_W:0]        count_r;
    logic                  overflow_r;
    logic                  rsp_valid_r, rsp_hit_r, rsp_drop_r;
    logic [IDX_W-1:0]      rsp_index_r;
    logic [HASH_WIDTH-1:0] rsp_hash_r, rsp_map_r;

    logic [DEPTH-1:0]      hit_vec_s;
    logic [IDX_W-1:0]      hit_idx_s;
    logic                  hit_any_s;
    logic                  accept_s, full_s, op_ins_s, op_clr_s;
    logic                  wr_en_s, wr_new_s, inc_count_s, bump_victim_s, drop_s;
    logic [IDX_W-1:0]      wr_idx_s;

    assign accept_s  = req_valid && (state_r == ST_IDLE);
    assign full_s    = (count_r == (IDX_W+1)'(DEPTH));
    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_hit   = rsp_hit_r;
    assign rsp_drop  = rsp_drop_r;
    assign rsp_index = rsp_index_r;
    assign rsp_hash  = rsp_hash_r;
    assign rsp_map   = rsp_map_r;
    assign count     = count_r;
    assign full      = full_s;
    assign overflow  = overflow_r;

    // Invalid entries never match, so an all-zero key is a legal lookup.
    always_comb begin
        hit_vec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec_s[i] = valid_r[i] && (data_r[i] == req_data);
        end
    end

    ct_prio_enc #(.DEPTH(DEPTH)) u_prio (
        .hits  (hit_vec_s),
        .index (hit_idx_s),
        .any   (hit_any_s)
    );

    // Opcode decode; the unused encoding behaves as a lookup.
    always_comb begin
        op_ins_s = 1'b0;
        op_clr_s = 1'b0;
        case (req_op)
            CT_INSERT: op_ins_s = 1'b1;
            CT_CLEAR:  op_clr_s = 1'b1;
            default:   op_ins_s = 1'b0;
        endcase
    end

    // Insert placement: duplicate key in place, else next free slot, else victim or drop.
    always_comb begin
        wr_en_s       = 1'b0;
        wr_new_s      = 1'b0;
        wr_idx_s      = '0;
        inc_count_s   = 1'b0;
        bump_victim_s = 1'b0;
        drop_s        = 1'b0;
        if (accept_s && op_ins_s) begin
            if (hit_any_s) begin
                wr_en_s  = 1'b1;
                wr_idx_s = hit_idx_s;
            end else if (!full_s) begin
                wr_en_s     = 1'b1;
                wr_new_s    = 1'b1;
                wr_idx_s    = count_r[IDX_W-1:0];
                inc_count_s = 1'b1;
            end else if (REPLACE != 0) begin
                wr_en_s       = 1'b1;
                wr_new_s      = 1'b1;
                wr_idx_s      = victim_r;
                bump_victim_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            data_r[clr_idx_r] <= '0;
            hash_r[clr_idx_r] <= '0;
            map_r[clr_idx_r]  <= '0;
        end else if (wr_en_s) begin
            hash_r[wr_idx_s] <= req_hash;
            map_r[wr_idx_s]  <= req_map;
            if (wr_new_s) begin
                data_r[wr_idx_s] <= req_data;
            end
        end
    end

    // Controller FSM, bookkeeping counters and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            valid_r     <= '0;
            clr_idx_r   <= '0;
            victim_r    <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_drop_r  <= 1'b0;
            rsp_index_r <= '0;
            rsp_hash_r  <= '0;
            rsp_map_r   <= '0;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_drop_r  <= 1'b0;
            rsp_index_r <= '0;
            rsp_hash_r  <= '0;
            rsp_map_r   <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && op_clr_s) begin
                        state_r    <= ST_CLEAR;
                        clr_idx_r  <= '0;
                        count_r    <= '0;
                        victim_r   <= '0;
                        overflow_r <= 1'b0;
                    end else if (accept_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_hit_r   <= hit_any_s;
                        rsp_drop_r  <= drop_s;
                        rsp_index_r <= op_ins_s ? wr_idx_s : hit_idx_s;
                        if (!op_ins_s && hit_any_s) begin
                            rsp_hash_r <= hash_r[hit_idx_s];
                            rsp_map_r  <= map_r[hit_idx_s];
                        end
                        if (wr_new_s) valid_r[wr_idx_s] <= 1'b1;
                        if (inc_count_s) count_r <= count_r + (IDX_W+1)'(1);
                        if (bump_victim_s) victim_r <= victim_r + IDX_W'(1);
                        if (drop_s) overflow_r <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    valid_r[clr_idx_r] <= 1'b0;
                    clr_idx_r          <= clr_idx_r + IDX_W'(1);
                    // Completion pulse lands in the same cycle the last entry is swept.
                    if (clr_idx_r == IDX_W'(DEPTH - 2)) rsp_valid_r <= 1'b1;
                    if (clr_idx_r == IDX_W'(DEPTH - 1)) state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conflict_cam.sv
// Directed plus randomized bench for conflict_cam; drop and replace variants share stimulus.
module tb_conflict_cam;
    import lzw_ct_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int HW    = 12;
    localparam int IW    = 2;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic [1:0] req_op;
    logic [DW-1:0] req_data;
    logic [HW-1:0] req_hash, req_map;
    logic [1:0] ready, rv, hit, drop, full, ovf;
    logic [1:0][IW-1:0] ridx;
    logic [1:0][HW-1:0] rhash, rmap;
    logic [1:0][IW:0] cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per instance (0 = drop, 1 = replace)
    logic [DW-1:0] m_data  [2][DEPTH];
    logic [HW-1:0] m_hash  [2][DEPTH];
    logic [HW-1:0] m_map   [2][DEPTH];
    bit            m_valid [2][DEPTH];
    int            m_count [2];
    int            m_victim[2];
    int            m_busy  [2];
    bit            m_ovf   [2];
    bit e_rv[2], e_hit[2], e_drop[2];
    int e_idx[2], e_hash[2], e_map[2];

    logic [DW-1:0] keys [8];

    always #5 clk = ~clk;

    conflict_cam #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .HASH_WIDTH(HW), .REPLACE(0)) u_cam0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[0]), .req_op(req_op),
        .req_data(req_data), .req_hash(req_hash), .req_map(req_map), .rsp_valid(rv[0]),
        .rsp_hit(hit[0]), .rsp_drop(drop[0]), .rsp_index(ridx[0]), .rsp_hash(rhash[0]),
        .rsp_map(rmap[0]), .count(cnt[0]), .full(full[0]), .overflow(ovf[0])
    );

    conflict_cam #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .HASH_WIDTH(HW), .REPLACE(1)) u_cam1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[1]), .req_op(req_op),
        .req_data(req_data), .req_hash(req_hash), .req_map(req_map), .rsp_valid(rv[1]),
        .rsp_hit(hit[1]), .rsp_drop(drop[1]), .rsp_index(ridx[1]), .rsp_hash(rhash[1]),
        .rsp_map(rmap[1]), .count(cnt[1]), .full(full[1]), .overflow(ovf[1])
    );

    task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) m_valid[k][i] = 1'b0;
            m_count[k] = 0; m_victim[k] = 0; m_busy[k] = 0; m_ovf[k] = 1'b0;
            e_rv[k] = 1'b0; e_hit[k] = 1'b0; e_drop[k] = 1'b0;
            e_idx[k] = 0; e_hash[k] = 0; e_map[k] = 0;
        end
    endtask

    task automatic model_cycle(input bit v, input logic [1:0] op, input logic [DW-1:0] d,
                               input logic [HW-1:0] h, input logic [HW-1:0] m);
        int hi;
        for (int k = 0; k < 2; k++) begin
            e_rv[k] = 1'b0; e_hit[k] = 1'b0; e_drop[k] = 1'b0;
            e_idx[k] = 0; e_hash[k] = 0; e_map[k] = 0;
            if (m_busy[k] > 0) begin
                m_busy[k]--;
                e_rv[k] = (m_busy[k] == 1);
            end else if (v) begin
                hi = -1;
                for (int i = DEPTH - 1; i >= 0; i--) if (m_valid[k][i] && m_data[k][i] == d) hi = i;
                if (op == 2'd2) begin
                    for (int i = 0; i < DEPTH; i++) m_valid[k][i] = 1'b0;
                    m_count[k] = 0; m_victim[k] = 0; m_ovf[k] = 1'b0; m_busy[k] = DEPTH;
                end else if (op == 2'd1) begin
                    e_rv[k] = 1'b1;
                    if (hi >= 0) begin
                        e_hit[k] = 1'b1; e_idx[k] = hi;
                        m_hash[k][hi] = h; m_map[k][hi] = m;
                    end else begin
                        if (m_count[k] < DEPTH) begin
                            hi = m_count[k]; m_count[k]++;
                        end else if (k == 1) begin
                            hi = m_victim[k]; m_victim[k] = (m_victim[k] + 1) % DEPTH;
                        end else begin
                            e_drop[k] = 1'b1; m_ovf[k] = 1'b1;
                        end
                        if (hi >= 0) begin
                            e_idx[k] = hi; m_valid[k][hi] = 1'b1; m_data[k][hi] = d;
                            m_hash[k][hi] = h; m_map[k][hi] = m;
                        end
                    end
                end else begin
                    e_rv[k] = 1'b1;
                    if (hi >= 0) begin
                        e_hit[k] = 1'b1; e_idx[k] = hi;
                        e_hash[k] = int'(m_hash[k][hi]); e_map[k] = int'(m_map[k][hi]);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check("req_ready", k, 64'(ready[k]), 64'(m_busy[k] == 0));
            check("rsp_valid", k, 64'(rv[k]), 64'(e_rv[k]));
            check("rsp_hit", k, 64'(hit[k]), 64'(e_hit[k]));
            check("rsp_drop", k, 64'(drop[k]), 64'(e_drop[k]));
            check("rsp_index", k, 64'(ridx[k]), 64'(e_idx[k]));
            check("rsp_hash", k, 64'(rhash[k]), 64'(e_hash[k]));
            check("rsp_map", k, 64'(rmap[k]), 64'(e_map[k]));
            check("count", k, 64'(cnt[k]), 64'(m_count[k]));
            check("full", k, 64'(full[k]), 64'(m_count[k] == DEPTH));
            check("overflow", k, 64'(ovf[k]), 64'(m_ovf[k]));
        end
    endtask

    task automatic step(input bit v, input logic [1:0] op, input logic [DW-1:0] d,
                        input logic [HW-1:0] h, input logic [HW-1:0] m);
        @(negedge clk);
        rst = 1'b0; req_valid = v; req_op = op; req_data = d; req_hash = h; req_map = m;
        model_cycle(v, op, d, h, m);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_data = '0; req_hash = '0; req_map = '0;
        keys[0] = 64'h0; keys[1] = 64'h11; keys[2] = 64'h22; keys[3] = 64'h33;
        keys[4] = 64'h44; keys[5] = 64'h55; keys[6] = 64'hFFFF_FFFF_FFFF_FFFF; keys[7] = 64'h8000_0000_0000_0001;
        do_reset();
        do_reset();

        // Zero key is not matched while invalid, then becomes a legal stored key
        step(1'b1, 2'd0, 64'h0, 12'h0, 12'h0);
        step(1'b1, 2'd1, 64'h0, 12'h5, 12'h7);
        step(1'b1, 2'd0, 64'h0, 12'h0, 12'h0);

        // Clear, then fill to capacity
        step(1'b1, 2'd2, 64'h0, 12'h0, 12'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd0, 64'h0, 12'h0, 12'h0);
        step(1'b1, 2'd1, 64'h11, 12'h101, 12'h201);
        step(1'b1, 2'd1, 64'h22, 12'h102, 12'h202);
        step(1'b1, 2'd1, 64'h33, 12'h103, 12'h203);
        step(1'b1, 2'd1, 64'h44, 12'h104, 12'h204);
        step(1'b0, 2'd0, 64'h0, 12'h0, 12'h0);

        // Duplicate insert updates in place
        step(1'b1, 2'd1, 64'h22, 12'h9, 12'hA);
        step(1'b1, 2'd0, 64'h22, 12'h0, 12'h0);

        // Full: drop on instance 0, round-robin overwrite on instance 1
        step(1'b1, 2'd1, 64'h55, 12'h5, 12'h5);
        step(1'b1, 2'd1, 64'h66, 12'h6, 12'h6);
        step(1'b1, 2'd1, 64'h77, 12'h7, 12'h7);
        step(1'b1, 2'd1, 64'h88, 12'h8, 12'h8);
        step(1'b1, 2'd1, 64'h99, 12'h9, 12'h9);
        step(1'b1, 2'd0, 64'h11, 12'h0, 12'h0);
        step(1'b1, 2'd3, 64'h99, 12'h0, 12'h0);

        // Clear again, then back-to-back insert and lookup of the same key
        step(1'b1, 2'd2, 64'h0, 12'h0, 12'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd1, 64'h77, 12'h1, 12'h1);
        step(1'b1, 2'd1, 64'hAB, 12'h3C, 12'h4D);
        step(1'b1, 2'd0, 64'hAB, 12'h0, 12'h0);
        step(1'b0, 2'd0, 64'h0, 12'h0, 12'h0);

        // Reset in the middle of a clear sweep
        step(1'b1, 2'd2, 64'h0, 12'h0, 12'h0);
        step(1'b0, 2'd0, 64'h0, 12'h0, 12'h0);
        do_reset();
        step(1'b1, 2'd0, 64'hAB, 12'h0, 12'h0);

        // Randomized traffic over a small key pool to force hits, fills and clears
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [1:0] op;
            r = int'($urandom_range(0, 99));
            op = (r < 45) ? 2'd0 : (r < 90) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
            step($urandom_range(0, 3) != 0, op, keys[$urandom_range(0, 7)],
                 HW'($urandom), HW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
